// File: rtl/cmd_slot_packer.sv
// Issue stage that places one held DRAM command per bundle into its earliest legal PHY slot,
// tracking elapsed tCK across bundles so command spacing is honoured to the exact tCK.
module cmd_slot_packer #(
    parameter int unsigned      nCK_PER_CLK = 4,
    parameter int unsigned      CMD_W       = 24,
    parameter int unsigned      DELAY_W     = 8,
    parameter logic [CMD_W-1:0] NOP_CMD     = '1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CMD_W-1:0]             in_cmd,
    input  logic [DELAY_W-1:0]           in_delay,
    output logic [nCK_PER_CLK*CMD_W-1:0] phy_cmd,
    output logic [nCK_PER_CLK-1:0]       phy_slot_valid,
    output logic                         busy
);

    localparam int unsigned SLOT_W = $clog2(nCK_PER_CLK);
    localparam logic [DELAY_W:0] SINCE_MAX = {1'b1, {DELAY_W{1'b0}}};

    logic                         hold_valid_r;
    logic [CMD_W-1:0]             hold_cmd_r;
    logic [DELAY_W-1:0]           hold_delay_r;
    logic [DELAY_W:0]             since_r;
    logic [DELAY_W:0]             since_d;
    logic [DELAY_W+1:0]           since_sum;
    logic signed [DELAY_W+1:0]    need;
    logic                         issue_now;
    logic [SLOT_W-1:0]            slot;
    logic                         accept;
    logic [nCK_PER_CLK*CMD_W-1:0] bundle_d;
    logic [nCK_PER_CLK-1:0]       slot_valid_d;

    // Remaining tCK before the held command may go; positive values index into this bundle.
    assign need = $signed({2'b00, hold_delay_r}) - $signed({1'b0, since_r});

    always_comb begin
        issue_now = 1'b0;
        slot      = '0;
        if (hold_valid_r) begin
            if (need[DELAY_W+1] || (need == '0)) begin
                issue_now = 1'b1;
            end else if (need < $signed((DELAY_W+2)'(nCK_PER_CLK))) begin
                issue_now = 1'b1;
                slot      = need[SLOT_W-1:0];
            end
        end
    end

    assign in_ready = !hold_valid_r || issue_now;
    assign accept   = in_valid && in_ready;
    assign busy     = hold_valid_r;

    always_comb begin
        since_sum = {1'b0, since_r} + (DELAY_W+2)'(nCK_PER_CLK);
        if (issue_now) begin
            since_d = (DELAY_W+1)'(nCK_PER_CLK) - (DELAY_W+1)'(slot);
        end else if (since_sum > {1'b0, SINCE_MAX}) begin
            since_d = SINCE_MAX;
        end else begin
            since_d = since_sum[DELAY_W:0];
        end
    end

    always_comb begin
        bundle_d     = {nCK_PER_CLK{NOP_CMD}};
        slot_valid_d = '0;
        for (int i = 0; i < int'(nCK_PER_CLK); i++) begin
            if (issue_now && (slot == SLOT_W'(i))) begin
                bundle_d[i*CMD_W +: CMD_W] = hold_cmd_r;
                slot_valid_d[i]            = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_r   <= 1'b0;
            hold_cmd_r     <= NOP_CMD;
            hold_delay_r   <= '0;
            since_r        <= SINCE_MAX;
            phy_cmd        <= {nCK_PER_CLK{NOP_CMD}};
            phy_slot_valid <= '0;
        end else begin
            if (accept) begin
                hold_valid_r <= 1'b1;
                hold_cmd_r   <= in_cmd;
                hold_delay_r <= in_delay;
            end else if (issue_now) begin
                hold_valid_r <= 1'b0;
            end
            since_r        <= since_d;
            phy_cmd        <= bundle_d;
            phy_slot_valid <= slot_valid_d;
        end
    end

endmodule

// File: tb/tb_cmd_slot_packer.sv
// Bench for cmd_slot_packer: absolute-tCK reference model checked every cycle, plus directed
// scenarios with hand-computed slot placements.
module tb_cmd_slot_packer;

    localparam int unsigned N       = 4;
    localparam int unsigned CMD_W   = 24;
    localparam int unsigned DELAY_W = 8;
    localparam logic [CMD_W-1:0] NOP = '1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [CMD_W-1:0]       in_cmd = '0;
    logic [DELAY_W-1:0]     in_delay = '0;
    logic [N*CMD_W-1:0]     phy_cmd;
    logic [N-1:0]           phy_slot_valid;
    logic                   busy;

    int n_checks = 0;
    int n_fail   = 0;

    cmd_slot_packer #(
        .nCK_PER_CLK(N),
        .CMD_W      (CMD_W),
        .DELAY_W    (DELAY_W),
        .NOP_CMD    (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_cmd        (in_cmd),
        .in_delay      (in_delay),
        .phy_cmd       (phy_cmd),
        .phy_slot_valid(phy_slot_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: commands placed on an absolute tCK timeline.
    bit             model_live = 0;
    bit             m_held = 0;
    logic [CMD_W-1:0] m_cmd;
    longint         m_delay = 0;
    longint         m_last = -100000;
    longint         m_cycle = 0;
    logic [N*CMD_W-1:0] exp_phy = {N{NOP}};
    logic [N-1:0]   exp_valid = '0;

    function automatic void m_eval(output bit iss, output int slot);
        longint start    = m_cycle * N;
        longint earliest = m_last + m_delay;
        iss  = 0;
        slot = 0;
        if (m_held) begin
            if (earliest <= start) iss = 1;
            else if (earliest < start + N) begin
                iss  = 1;
                slot = int'(earliest - start);
            end
        end
    endfunction

    always @(posedge clk) begin
        bit iss;
        int slot;
        if (rst) begin
            model_live = 1;
            m_held     = 0;
            m_last     = -100000;
            exp_phy    = {N{NOP}};
            exp_valid  = '0;
        end else begin
            m_eval(iss, slot);
            exp_phy   = {N{NOP}};
            exp_valid = '0;
            if (iss) begin
                exp_phy[slot*CMD_W +: CMD_W] = m_cmd;
                exp_valid[slot]              = 1'b1;
                m_last                       = m_cycle * N + slot;
            end
            if (in_valid && (!m_held || iss)) begin
                m_held  = 1;
                m_cmd   = in_cmd;
                m_delay = longint'(in_delay);
            end else if (iss) begin
                m_held = 0;
            end
        end
        m_cycle++;
    end

    always @(negedge clk) begin
        bit iss;
        int slot;
        if (model_live) begin
            m_eval(iss, slot);
            check("model_phy_cmd", 128'(phy_cmd), 128'(exp_phy));
            check("model_slot_valid", 128'(phy_slot_valid), 128'(exp_valid));
            check("model_busy", 128'(busy), 128'(m_held));
            check("model_in_ready", 128'(in_ready), 128'(!m_held || iss));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [CMD_W-1:0] cmd, input logic [DELAY_W-1:0] dly);
        bit done = 0;
        in_valid = 1'b1;
        in_cmd   = cmd;
        in_delay = dly;
        for (int k = 0; k < 64 && !done; k++) begin
            if (in_ready) done = 1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 128'(0), 128'(1));
    endtask

    task automatic lit(input string name, input logic [N-1:0] ev, input logic [CMD_W-1:0] ec);
        logic [N*CMD_W-1:0] eb = {N{NOP}};
        for (int s = 0; s < int'(N); s++) if (ev[s]) eb[s*CMD_W +: CMD_W] = ec;
        check({name, "_valid"}, 128'(phy_slot_valid), 128'(ev));
        check({name, "_cmd"}, 128'(phy_cmd), 128'(eb));
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        lit("reset", 4'b0000, NOP);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_ready", 128'(in_ready), 128'(1));

        // A(5) after reset -> slot 0; B(6) held next cycle -> slot 2
        send(24'hA0000A, 8'd5);
        lit("a_hold", 4'b0000, NOP);
        send(24'hB0000B, 8'd6);
        lit("a_slot0", 4'b0001, 24'hA0000A);
        // C(13) after B in slot 2 -> two NOP bundles, then slot 3
        send(24'hC0000C, 8'd13);
        lit("b_slot2", 4'b0100, 24'hB0000B);
        check("c_wait_ready0", 128'(in_ready), 128'(0));
        check("c_wait_busy0", 128'(busy), 128'(1));
        // D(1) offered while C waits: accepted only in C's issue cycle
        in_valid = 1'b1;
        in_cmd   = 24'hD0000D;
        in_delay = 8'd1;
        tick();
        lit("c_wait1", 4'b0000, NOP);
        check("c_wait_ready1", 128'(in_ready), 128'(0));
        check("c_wait_busy1", 128'(busy), 128'(1));
        tick();
        lit("c_wait2", 4'b0000, NOP);
        check("d_ready_on_issue", 128'(in_ready), 128'(1));
        tick();
        in_valid = 1'b0;
        lit("c_slot3", 4'b1000, 24'hC0000C);
        tick();
        lit("d_slot0", 4'b0001, 24'hD0000D);

        // slot 3 then delay 0 -> slot 0, same as delay 1
        repeat (3) tick();
        send(24'h111111, 8'd0);
        send(24'h222222, 8'd7);
        lit("x_slot0", 4'b0001, 24'h111111);
        send(24'h333333, 8'd0);
        lit("y_slot3", 4'b1000, 24'h222222);
        tick();
        lit("z_slot0", 4'b0001, 24'h333333);

        // reset while Q waits with need = 7
        repeat (3) tick();
        send(24'h444444, 8'd0);
        send(24'h555555, 8'd11);
        lit("p_slot0", 4'b0001, 24'h444444);
        check("q_waiting", 128'(busy), 128'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lit("rst_nop0", 4'b0000, NOP);
        check("rst_busy", 128'(busy), 128'(0));
        tick();
        lit("rst_nop1", 4'b0000, NOP);
        check("rst_ready", 128'(in_ready), 128'(1));
        tick();
        lit("rst_nop2", 4'b0000, NOP);
        send(24'h666666, 8'd200);
        tick();
        lit("d200_slot0", 4'b0001, 24'h666666);

        // long idle must saturate elapsed time rather than wrap
        repeat (150) tick();
        send(24'h777777, 8'd255);
        tick();
        lit("sat_slot0", 4'b0001, 24'h777777);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cmd_slot_packer.md
Name: cmd_slot_packer

Overview:
- Downstream issue stage of the scheduler. Takes one DRAM command per fabric clock, each tagged with a minimum tCK spacing from the previously issued command.
- Places the command into the earliest legal slot of an nCK_PER_CLK-wide PHY command bundle. All other slots in that bundle are filled with NOP.
- Tracks elapsed tCK across bundle boundaries, so timing parameters, including deliberately violated (reduced) ones, are honoured exactly to the tCK.

Parameters:
- nCK_PER_CLK, 4, DRAM clocks per fabric clock (slots per bundle); a power of two, 2 or 4.
- CMD_W, 24, width of one encoded command (cs/ras/cas/we/bank/addr).
- DELAY_W, 8, width of the per-command spacing field in tCK.
- NOP_CMD, all-ones CMD_W value, encoding driven in empty slots.

Ports:
- clk  in  1  fabric clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  command offered
- in_ready  out  1  packer can accept a command this cycle
- in_cmd  in  CMD_W  encoded command
- in_delay  in  DELAY_W  minimum tCK from the previously issued command's slot to this command's slot
- phy_cmd  out  nCK_PER_CLK*CMD_W  registered bundle; slot 0 in bits [CMD_W-1:0] is earliest in time
- phy_slot_valid  out  nCK_PER_CLK  one-hot (or zero) marking the slot holding a real command
- busy  out  1  a held command is waiting for issue

Behaviour:
- Handshake: a transfer occurs when in_valid && in_ready.
  - in_ready = !hold_valid_r || issue_now, so a new command may be accepted in the same cycle the held one issues.
  - in_cmd and in_delay are sampled only on transfer.
- Hold stage: an accepted command goes into hold_cmd_r and hold_delay_r, and hold_valid_r is set to 1. busy = hold_valid_r.
- since_r is DELAY_W+1 bits, unsigned and saturating. It holds the tCK elapsed from the last issued command's slot to slot 0 of the bundle being built this cycle. It saturates at 2^DELAY_W.
- Slot computation, only when hold_valid_r = 1:
  - need = hold_delay_r - since_r, signed and one bit wider.
  - If need <= 0: issue_now = 1, slot = 0.
  - Else if need < nCK_PER_CLK: issue_now = 1, slot = need.
  - Else: issue_now = 0.
- Issue (issue_now = 1), at the next clk edge:
  - phy_cmd slot[slot] = hold_cmd_r; every other slot = NOP_CMD.
  - phy_slot_valid = 1 << slot.
  - since_r = nCK_PER_CLK - slot.
  - hold_valid_r clears unless a new command is accepted in the same cycle.
- No issue: phy_cmd = all NOP_CMD, phy_slot_valid = 0, since_r = min(since_r + nCK_PER_CLK, 2^DELAY_W).
- Throughput and latency:
  - At most one command per bundle.
  - Minimum latency from transfer at edge T to the command on phy_cmd is 2 edges (T+1 hold, T+2 output).
- in_delay of 0 or 1 behaves identically, because since_r is always >= 1 after an issue.
- Saturation guarantees the first command after reset, or after an idle period, issues in slot 0.
- Reset (any cycle, including while a command is held and waiting):
  - hold_valid_r = 0, so the held command is dropped.
  - since_r = 2^DELAY_W.
  - phy_cmd = all NOP_CMD, phy_slot_valid = 0, busy = 0, in_ready = 1 from the first cycle after reset.
- Wrap-around: need may span any number of bundles. The packer waits whole bundles while since_r grows by nCK_PER_CLK each cycle, then issues in slot need.

Test Plan:
- After reset, send A (delay 5) -> A on phy_cmd slot 0, phy_slot_valid = 0001, two edges after transfer; other slots NOP.
- A issued in slot 0, then B (delay 6) held the next cycle -> since_r = 4, need = 2 -> B in slot 2 of the immediately following bundle (spacing 6 tCK).
- A issued in slot 2, then B (delay 13) -> two all-NOP bundles, then B in slot 3 (2+4+4+3 = 13 tCK); in_ready = 0 and busy = 1 during the wait.
- A issued in slot 3, then B (delay 1) -> B in slot 0 of the next bundle; with B (delay 0) -> identical result.
- Backpressure: C offered while B waits -> C not accepted until B's issue cycle, accepted in that same cycle, then issued per its own delay relative to B's slot.
- Assert rst while B is waiting (need = 7) -> the next bundles are all NOP, busy = 0; a new command D (delay 200) after reset issues in slot 0.
